// File: rtl/spike_aer_encoder_pkg.sv
// Shared constants and event word type for the AER encoder.
package spike_aer_encoder_pkg;

  localparam int unsigned N_NEURONS  = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned TS_W       = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DROP_W     = 8;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } aer_evt_t;

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready address-event stream.
interface spike_aer_encoder_if;
  import spike_aer_encoder_pkg::*;

  logic              evt_valid;
  logic              evt_ready;
  logic [ADDR_W-1:0] evt_addr;
  logic [TS_W-1:0]   evt_ts;

  modport master (output evt_valid, output evt_addr, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_addr, input evt_ts, output evt_ready);
endinterface

// File: rtl/spike_aer_encoder_sync_fifo.sv
// Show-ahead synchronous FIFO; accepts a push when full only if a pop happens too.
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Head is forced to zero when empty so stale data never leaks out.
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: rtl/spike_aer_encoder.sv
// Parallel spike lines -> round-robin arbitrated AER event stream with drop counting.
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_NEURONS-1:0]    spike_in,
  spike_aer_encoder_if.master     evt,
  output logic [CNT_W-1:0]        fifo_count,
  output logic [DROP_W-1:0]       drop_count
);
  logic [TS_W-1:0]      ts_ctr_q;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]      ts_hold_q [N_NEURONS];
  logic [TS_W-1:0]      ts_hold_d [N_NEURONS];
  logic [ADDR_W-1:0]    rr_ptr_q;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic [DROP_W:0]      drop_sum;
  logic [ADDR_W:0]      n_drop;
  logic [ADDR_W-1:0]    grant;
  logic                 grant_valid;
  logic                 fifo_full, fifo_empty, pop, push_ok;
  aer_evt_t             push_evt, head_evt;

  assign pop        = evt.evt_valid && evt.evt_ready;
  assign push_ok    = !fifo_full || pop;
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_addr  = head_evt.addr;
  assign evt.evt_ts    = head_evt.ts;
  assign drop_count    = drop_q;

  // Round-robin search starting at rr_ptr; suppressed when the FIFO cannot take a word.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      idx = rr_ptr_q + ADDR_W'(k);
      if (!grant_valid && pending_q[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
    if (!push_ok) grant_valid = 1'b0;
    push_evt.addr = grant;
    push_evt.ts   = ts_hold_q[grant];
  end

  // Capture new spikes, retire the granted one, and count spikes that hit a busy slot.
  always_comb begin
    pending_d = pending_q;
    ts_hold_d = ts_hold_q;
    n_drop    = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (en && spike_in[i]) begin
        pending_d[i] = 1'b1;
        // A granted slot frees up this cycle, so the new spike re-arms it with a fresh ts.
        if (!pending_q[i] || (grant_valid && grant == ADDR_W'(i))) begin
          ts_hold_d[i] = ts_ctr_q;
        end else begin
          n_drop = n_drop + {{ADDR_W{1'b0}}, 1'b1};
        end
      end else if (grant_valid && grant == ADDR_W'(i)) begin
        pending_d[i] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
    drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Timestamp, pending slots, arbiter pointer and drop counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_ctr_q  <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      drop_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) ts_hold_q[i] <= '0;
    end else begin
      if (en) ts_ctr_q <= ts_ctr_q + 1'b1;
      pending_q <= pending_d;
      ts_hold_q <= ts_hold_d;
      drop_q    <= drop_d;
      if (grant_valid) rr_ptr_q <= grant + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(aer_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_valid),
    .pop   (pop),
    .din   (push_evt),
    .dout  (head_evt),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule
